// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer, flush to NOP bubbles.
// Optional statistics counters (stall_cnt, xfer_cnt) enabled by defining PIPE_STATS_EN.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  xfer_cnt
`endif
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_reg: CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic              w_in_fire;
   logic              w_out_fire;

   assign w_in_fire  = in_valid  & in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         unique case (r_state)
            S_EMPTY: if (w_in_fire) w_state_nxt = S_ONE;
            S_ONE: begin
               if (w_in_fire && !w_out_fire)      w_state_nxt = S_FULL;
               else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_out_fire) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Handshake flags depend only on the state register, so out_ready never reaches in_ready.
   always_comb begin
      in_ready  = (r_state != S_FULL);
      out_valid = (r_state != S_EMPTY);
      out_data  = r_main_data;
      out_ctrl  = r_main_ctrl;
   end

   // main_ctrl is zeroed every time the stage drains so an empty stage presents a NOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else if (flush) begin
         r_main_ctrl <= '0;
         r_skid_ctrl <= '0;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  r_main_data <= in_data;
                  r_main_ctrl <= in_ctrl;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_data <= in_data;
                  r_main_ctrl <= in_ctrl;
               end else if (w_in_fire) begin
                  r_skid_data <= in_data;
                  r_skid_ctrl <= in_ctrl;
               end else if (w_out_fire) begin
                  r_main_ctrl <= '0;
               end
            end
            S_FULL: begin
               if (w_out_fire) begin
                  r_main_data <= r_skid_data;
                  r_main_ctrl <= r_skid_ctrl;
               end
            end
            default: r_main_ctrl <= '0;
         endcase
      end
   end

`ifdef PIPE_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_xfer_cnt;

   // Saturating counters; flush deliberately leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_xfer_cnt  <= '0;
      end else begin
         if (out_valid && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_out_fire && (r_xfer_cnt != '1))
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign xfer_cnt  = r_xfer_cnt;
`endif

endmodule
